// File: rtl/cpu_pkg.sv
// Shared CPU-wide widths and the writeback source encoding.
package cpu_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned REG_NUM   = 32;

    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_ALU  = 2'd1,
        WB_LOAD = 2'd2
    } wb_src_e;

endpackage

// File: rtl/wb_load_fifo.sv
// Small synchronous FIFO buffering load returns ({rd, data}) ahead of the writeback port.
module wb_load_fifo #(
    parameter int unsigned WIDTH = 37,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // No push while full, even if a pop happens in the same cycle.
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/wb_merge_unit.sv
// Merges ALU results and buffered load returns onto the single regfile write port,
// tracking pending load destinations for decode hazard checks.
module wb_merge_unit import cpu_pkg::*; #(
    parameter int unsigned XLEN            = cpu_pkg::XLEN,
    parameter int unsigned LQ_DEPTH        = 2,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alu_wb_en,
    input  logic [REG_IDX_W-1:0] alu_rd,
    input  logic [XLEN-1:0]      alu_data,
    input  logic                 ld_issue,
    input  logic [REG_IDX_W-1:0] ld_issue_rd,
    output logic                 ld_issue_ready,
    input  logic                 ld_rsp_valid,
    output logic                 ld_rsp_ready,
    input  logic [REG_IDX_W-1:0] ld_rsp_rd,
    input  logic [XLEN-1:0]      ld_rsp_data,
    input  logic [REG_IDX_W-1:0] rs1_index,
    input  logic [REG_IDX_W-1:0] rs2_index,
    output logic                 rs1_busy,
    output logic                 rs2_busy,
    output logic                 wb_en,
    output logic [REG_IDX_W-1:0] wb_rd,
    output logic [XLEN-1:0]      wb_data
);

    localparam int unsigned ENTRY_W = REG_IDX_W + XLEN;
    localparam int unsigned CNT_W   = 4;

    logic                 fifo_full, fifo_empty, fifo_pop;
    logic [ENTRY_W-1:0]   fifo_head;
    logic [REG_IDX_W-1:0] head_rd;
    logic [XLEN-1:0]      head_data;
    wb_src_e              wb_src;
    logic [REG_IDX_W-1:0] sel_rd;
    logic [XLEN-1:0]      sel_data;
    logic                 wb_en_q, wb_en_d;
    logic [REG_IDX_W-1:0] wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]      wb_data_q, wb_data_d;
    logic [REG_NUM-1:0]   pending_q, pending_d;
    logic [CNT_W-1:0]     outstanding_q, outstanding_d;

    wb_load_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (LQ_DEPTH)
    ) u_load_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (ld_rsp_valid),
        .push_data_i ({ld_rsp_rd, ld_rsp_data}),
        .pop_i       (fifo_pop),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .head_o      (fifo_head)
    );

    assign {head_rd, head_data} = fifo_head;
    assign ld_rsp_ready   = !fifo_full;
    assign ld_issue_ready = (outstanding_q < CNT_W'(MAX_OUTSTANDING));
    assign rs1_busy       = pending_q[rs1_index];
    assign rs2_busy       = pending_q[rs2_index];
    assign wb_en          = wb_en_q;
    assign wb_rd          = wb_rd_q;
    assign wb_data        = wb_data_q;

    // Fixed priority: ALU always wins, loads drain only on idle ALU cycles.
    always_comb begin
        wb_src   = WB_NONE;
        sel_rd   = head_rd;
        sel_data = head_data;
        if (alu_wb_en) begin
            wb_src   = WB_ALU;
            sel_rd   = alu_rd;
            sel_data = alu_data;
        end else if (!fifo_empty) begin
            wb_src = WB_LOAD;
        end
    end

    assign fifo_pop = (wb_src == WB_LOAD);

    always_comb begin
        wb_en_d   = 1'b0;
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;
        if (wb_src != WB_NONE) begin
            wb_en_d   = (sel_rd != '0);
            wb_rd_d   = sel_rd;
            wb_data_d = sel_data;
        end
    end

    // Issue-set is applied after pop-clear so a re-issue of the same rd stays pending.
    always_comb begin
        pending_d = pending_q;
        if (fifo_pop) pending_d[head_rd] = 1'b0;
        if (ld_issue && (ld_issue_rd != '0)) pending_d[ld_issue_rd] = 1'b1;
        pending_d[0] = 1'b0;

        outstanding_d = outstanding_q;
        case ({ld_issue, fifo_pop})
            2'b10:   if (ld_issue_ready) outstanding_d = outstanding_q + CNT_W'(1);
            2'b01:   if (outstanding_q != '0) outstanding_d = outstanding_q - CNT_W'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_en_q       <= 1'b0;
            wb_rd_q       <= '0;
            wb_data_q     <= '0;
            pending_q     <= '0;
            outstanding_q <= '0;
        end else begin
            wb_en_q       <= wb_en_d;
            wb_rd_q       <= wb_rd_d;
            wb_data_q     <= wb_data_d;
            pending_q     <= pending_d;
            outstanding_q <= outstanding_d;
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(ld_issue && !ld_issue_ready));
            assert (!(alu_wb_en && pending_q[alu_rd]));
        end
    end
`endif

endmodule

// File: doc/wb_merge_unit.md
Name: wb_merge_unit

Overview:
Writeback-stage merger directly upstream of the register file write port. Combines single-cycle ALU/CSR results with multi-cycle data-memory load returns into the one regfile write port (wb_en/wb_rd/wb_data). Buffers load returns in a small FIFO. Keeps a pending-load scoreboard so decode can detect RAW/WAW hazards on loaded registers.

Parameters:
XLEN, 32, datapath width
LQ_DEPTH, 2, load-return FIFO entries (power of 2, >=2)
MAX_OUTSTANDING, 4, max loads issued but not yet written back (<=15)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
alu_wb_en  in  1  ALU result valid this cycle; always accepted, never stalled
alu_rd  in  5  ALU destination index
alu_data  in  XLEN  ALU result
ld_issue  in  1  load issued to memory this cycle
ld_issue_rd  in  5  destination of issued load
ld_issue_ready  out  1  outstanding < MAX_OUTSTANDING; combinational
ld_rsp_valid  in  1  memory load response valid
ld_rsp_ready  out  1  FIFO not full; combinational
ld_rsp_rd  in  5  response destination index
ld_rsp_data  in  XLEN  response data (already sign/zero-extended)
rs1_index  in  5  decode lookup
rs2_index  in  5  decode lookup
rs1_busy  out  1  pending[rs1_index]; combinational
rs2_busy  out  1  pending[rs2_index]; combinational
wb_en  out  1  regfile write enable; registered
wb_rd  out  5  regfile write index; registered
wb_data  out  XLEN  regfile write data; registered

Behaviour:
- Reset (async assert, sync-safe deassert): wb_en=0, wb_rd=0, wb_data=0, FIFO empty, pending=0, outstanding=0. Reset mid-operation drops all queued responses. Memory is reset by the same rst, so no stale responses arrive.
- Response accept: ld_rsp_valid && ld_rsp_ready pushes {rd,data}. ld_rsp_ready=0 when FIFO holds LQ_DEPTH entries; no same-cycle push/pop bypass when full.
- Arbitration (per cycle, fixed priority):
  - alu_wb_en=1: register alu_* to wb_*.
  - alu_wb_en=0 and FIFO non-empty: pop head, register it to wb_*.
  - otherwise wb_en=0; wb_rd/wb_data hold their previous values.
- Latency: ALU result appears at wb_* 1 cycle after presentation. A load response into an empty FIFO with no ALU traffic pops the cycle after acceptance and appears at wb_* on the following edge (2 cycles). Empty-FIFO bypass is not permitted.
- Writes to x0: wb_en is forced 0 when the selected rd==0. The FIFO entry is still popped and the outstanding count is still decremented. wb_rd/wb_data update normally.
- Scoreboard: 32-bit pending vector; bit 0 is hardwired 0.
  - Set on ld_issue when ld_issue_rd!=0.
  - Cleared when a load entry is popped to wb_* (same edge as wb_en rises).
  - Same-cycle set and clear of the same index: set wins.
  - rsN_busy is combinational from the registered vector; no pass-through of same-cycle issue.
- Outstanding counter, 4 bits:
  - +1 on ld_issue (including rd==0); -1 on load pop.
  - Both in the same cycle: unchanged.
  - ld_issue while !ld_issue_ready is a protocol violation; assert in simulation, counter saturates.
- Protocol assumption (upstream decode guarantees, checked by assertion): no ALU writeback to an rd whose pending bit is set.
- Starvation: continuous ALU traffic may stall FIFO drain indefinitely. This is acceptable; backpressure propagates through ld_rsp_ready.

Decomposition:
- Shared package cpu_pkg: XLEN, REG_IDX_W=5, REG_NUM=32, wb source encoding enum (WB_NONE, WB_ALU, WB_LOAD).
- One sub-module: wb_load_fifo, a parameterised synchronous FIFO (push/pop/full/empty/head, async active-high reset) holding {rd,data}.
- Arbiter, scoreboard and counter stay in the top.

Test Plan:
- ALU only: alu_wb_en=1, rd=5, data=0xDEADBEEF at cycle N -> wb_en=1, wb_rd=5, wb_data=0xDEADBEEF at N+1; no write at N+2 if idle.
- Single load: ld_issue rd=7 -> rs1_busy=1 for rs1_index=7. Response data=0x12345678 accepted at cycle N, no ALU -> wb write at N+2. Busy clears and outstanding returns to 0 in the same cycle.
- Contention: load response queued while alu_wb_en=1 for 3 cycles -> three ALU writes first, then the load write. With LQ_DEPTH=2 and a third response offered, ld_rsp_ready=0 until the first pop.
- x0 handling: ld_issue rd=0, then response rd=0 -> pending stays 0, wb_en never 1, outstanding returns to 0. Also alu rd=0 -> wb_en=0.
- Outstanding limit: 4 back-to-back ld_issue with no responses -> ld_issue_ready=0. Issue plus pop in the same cycle -> ld_issue_ready unchanged. Re-issue of rd=9 while its older load pops -> pending[9] stays 1.
- Reset mid-operation: 2 queued responses and pending bits set, assert rst asynchronously mid-cycle -> wb_en=0, pending=0, ld_rsp_ready=1, ld_issue_ready=1 immediately, before the next clock edge.
